reorder_buffer: RTL

Circular in-order commit buffer between the dispatcher, the common data bus (CDB) and the register file. It allocates one entry per dispatched instruction and captures each result from the CDB. It retires the head entry to the register file through the `RoBRF_*` commit interface. On a mispredicted branch it pulses the flush/redirect outputs and empties itself.

---
 rtl/reorder_buffer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates an entry per dispatched instruction, captures
// CDB results, retires the head to the register file and flushes on a mispredict.
module reorder_buffer #(
  parameter int                      RoB_WIDTH    = 8,
  parameter int                      EX_REG_WIDTH = 6,
  parameter logic [EX_REG_WIDTH-1:0] NON_REG      = 6'b100000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  // dispatcher
  input  logic                    DPRoB_en,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_is_branch,
  input  logic                    DPRoB_pred,
  input  logic [31:0]             DPRoB_alt_pc,
  output logic                    RoBDP_full,
  output logic [RoB_WIDTH-1:0]    RoBDP_index,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qj,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qk,
  output logic                    RoBDP_Vj_rdy,
  output logic                    RoBDP_Vk_rdy,
  output logic [31:0]             RoBDP_Vj,
  output logic [31:0]             RoBDP_Vk,
  // common data bus
  input  logic                    CDB_en,
  input  logic [RoB_WIDTH-1:0]    CDB_index,
  input  logic [31:0]             CDB_value,
  input  logic                    CDB_taken,
  // commit interface
  output logic                    RoBRF_en,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [EX_REG_WIDTH-1:0] RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBRF_pre_judge,
  output logic                    RoB_clear,
  output logic [31:0]             RoB_new_pc
);

  localparam int                   DEPTH      = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0]   FULL_COUNT = {1'b1, {RoB_WIDTH{1'b0}}};
  localparam logic [RoB_WIDTH-1:0] PTR_ONE    = {{(RoB_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RoB_WIDTH:0]   CNT_ONE    = {{RoB_WIDTH{1'b0}}, 1'b1};

  // Pointers and per-entry status bits (reset).
  logic [RoB_WIDTH-1:0] head_q, head_d;
  logic [RoB_WIDTH-1:0] tail_q, tail_d;
  logic [RoB_WIDTH:0]   count_q, count_d;
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     ready_q, ready_d;

  // Entry payload (not reset).
  logic [DEPTH-1:0]        is_branch_q, is_branch_d;
  logic [DEPTH-1:0]        pred_q, pred_d;
  logic [DEPTH-1:0]        taken_q, taken_d;
  logic [EX_REG_WIDTH-1:0] rd_q     [DEPTH];
  logic [EX_REG_WIDTH-1:0] rd_d     [DEPTH];
  logic [31:0]             value_q  [DEPTH];
  logic [31:0]             value_d  [DEPTH];
  logic [31:0]             alt_pc_q [DEPTH];
  logic [31:0]             alt_pc_d [DEPTH];

  // Registered commit / redirect outputs.
  logic                    rf_en_q, rf_en_d;
  logic [RoB_WIDTH-1:0]    rf_index_q, rf_index_d;
  logic [EX_REG_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [31:0]             rf_value_q, rf_value_d;
  logic                    pre_judge_q, pre_judge_d;
  logic                    clear_q, clear_d;
  logic [31:0]             new_pc_q, new_pc_d;

  logic full;
  logic head_commit;
  logic head_mispredict;
  logic dispatch_ok;
  logic writeback_ok;

  // Commit decisions look only at registered state, so a CDB write becomes
  // visible to the commit logic one edge after it lands.
  assign full            = (count_q == FULL_COUNT);
  assign head_commit     = busy_q[head_q] & ready_q[head_q];
  assign head_mispredict = head_commit & is_branch_q[head_q] &
                           (taken_q[head_q] != pred_q[head_q]);
  assign dispatch_ok     = DPRoB_en & ~full & ~head_mispredict;
  assign writeback_ok    = CDB_en & busy_q[CDB_index] & ~head_mispredict;

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    is_branch_d = is_branch_q;
    pred_d      = pred_q;
    taken_d     = taken_q;
    rd_d        = rd_q;
    value_d     = value_q;
    alt_pc_d    = alt_pc_q;

    if (writeback_ok) begin
      ready_d[CDB_index] = 1'b1;
      value_d[CDB_index] = CDB_value;
      taken_d[CDB_index] = CDB_taken;
    end

    if (head_mispredict) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (head_commit) begin
        busy_d[head_q] = 1'b0;
        head_d         = head_q + PTR_ONE;
      end
      // Tail never aliases a committing head: when count is 0 the head is idle.
      if (dispatch_ok) begin
        busy_d[tail_q]      = 1'b1;
        ready_d[tail_q]     = 1'b0;
        rd_d[tail_q]        = DPRoB_rd;
        is_branch_d[tail_q] = DPRoB_is_branch;
        pred_d[tail_q]      = DPRoB_pred;
        alt_pc_d[tail_q]    = DPRoB_alt_pc;
        tail_d              = tail_q + PTR_ONE;
      end
      case ({dispatch_ok, head_commit})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    rf_en_d     = 1'b0;
    rf_index_d  = rf_index_q;
    rf_rd_d     = rf_rd_q;
    rf_value_d  = rf_value_q;
    pre_judge_d = 1'b1;
    clear_d     = 1'b0;
    new_pc_d    = new_pc_q;

    if (head_mispredict) begin
      pre_judge_d = 1'b0;
      clear_d     = 1'b1;
      new_pc_d    = alt_pc_q[head_q];
    end else if (head_commit) begin
      rf_en_d    = 1'b1;
      rf_index_d = head_q;
      if (is_branch_q[head_q]) begin
        rf_rd_d    = NON_REG;
        rf_value_d = '0;
      end else begin
        rf_rd_d    = rd_q[head_q];
        rf_value_d = value_q[head_q];
      end
    end
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge values computed above regardless of statement order.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      rf_en_q     <= 1'b0;
      rf_index_q  <= '0;
      rf_rd_q     <= NON_REG;
      rf_value_q  <= '0;
      pre_judge_q <= 1'b1;
      clear_q     <= 1'b0;
      new_pc_q    <= '0;
    end else if (Sys_rdy) begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      rf_en_q     <= rf_en_d;
      rf_index_q  <= rf_index_d;
      rf_rd_q     <= rf_rd_d;
      rf_value_q  <= rf_value_d;
      pre_judge_q <= pre_judge_d;
      clear_q     <= clear_d;
      new_pc_q    <= new_pc_d;
    end
  end

  // NOTE: the payload array is deliberately left out of reset; an entry's
  // fields are only consumed while its busy bit (which is reset) is set.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rdy) begin
      is_branch_q <= is_branch_d;
      pred_q      <= pred_d;
      taken_q     <= taken_d;
      rd_q        <= rd_d;
      value_q     <= value_d;
      alt_pc_q    <= alt_pc_d;
    end
  end

  // Operand lookup with a same-cycle CDB bypass.
  always_comb begin
    RoBDP_Vj_rdy = ready_q[DPRoB_Qj];
    RoBDP_Vj     = value_q[DPRoB_Qj];
    RoBDP_Vk_rdy = ready_q[DPRoB_Qk];
    RoBDP_Vk     = value_q[DPRoB_Qk];
    if (CDB_en && (CDB_index == DPRoB_Qj)) begin
      RoBDP_Vj_rdy = 1'b1;
      RoBDP_Vj     = CDB_value;
    end
    if (CDB_en && (CDB_index == DPRoB_Qk)) begin
      RoBDP_Vk_rdy = 1'b1;
      RoBDP_Vk     = CDB_value;
    end
  end

  assign RoBDP_full      = full;
  assign RoBDP_index     = tail_q;
  assign RoBRF_en        = rf_en_q;
  assign RoBRF_RoB_index = rf_index_q;
  assign RoBRF_rd        = rf_rd_q;
  assign RoBRF_value     = rf_value_q;
  assign RoBRF_pre_judge = pre_judge_q;
  assign RoB_clear       = clear_q;
  assign RoB_new_pc      = new_pc_q;

endmodule
